// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// digit count, blank pattern and the active-low hex glyph table.
package seg_scan_driver_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed hex display driver with frame-aligned (tear-free)
// value updates and optional leading-zero blanking.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
)
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Value,
    input  logic        Load,
    input  logic        Enable,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic [2:0]  DigitIdx
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_divCnt;
    logic [2:0]       r_digitIdx;
    logic [31:0]      r_shadow;
    logic [31:0]      r_disp;
    logic             r_pending;

    logic             w_termCnt;
    logic             w_frameEdge;
    logic             w_lit;
    logic [31:0]      w_upper;
    logic [6:0]       w_seg;

    assign w_termCnt   = (r_divCnt == CNT_LAST);
    assign w_frameEdge = w_termCnt && (r_digitIdx == 3'(NUM_DIGITS - 1));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_divCnt   <= '0;
            r_digitIdx <= '0;
        end else if (w_termCnt) begin
            r_divCnt   <= '0;
            r_digitIdx <= r_digitIdx + 3'd1;
        end else begin
            r_divCnt   <= r_divCnt + 1'b1;
        end
    end

    // A load coinciding with the frame edge keeps pending set so its value
    // is shown one frame later; disp always takes the pre-edge shadow.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (Load) begin
                r_shadow  <= Value;
                r_pending <= 1'b1;
            end else if (w_frameEdge && r_pending) begin
                r_pending <= 1'b0;
            end
            if (w_frameEdge && r_pending) begin
                r_disp <= r_shadow;
            end
        end
    end

    // Shifting the current digit to the bottom gives both its nibble and,
    // via the remaining upper bits, the leading-zero test.
    assign w_upper = r_disp >> {r_digitIdx, 2'b00};

    hex_to_seg7 u_hexToSeg7 (
        .i_nibble (w_upper[3:0]),
        .o_seg    (w_seg)
    );

    assign w_lit = Enable && (!BLANK_LZ || (r_digitIdx == 3'd0) || (w_upper != 32'd0));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out7   <= SEG_BLANK;
            en_out <= 8'hFF;
        end else begin
            out7   <= w_lit ? w_seg : SEG_BLANK;
            en_out <= w_lit ? ~(8'b1 << r_digitIdx) : 8'hFF;
        end
    end

    assign DigitIdx = r_digitIdx;

endmodule
